// File: rtl/memory_responder_pkg.sv
// Shared definitions for the CPU memory responder: sequencer state encoding
// and the default geometry of the program/data memory.
package memory_responder_pkg;

  // Default word-address width (depth = 2**DEF_ADDR_WIDTH) and word width
  localparam int DEF_ADDR_WIDTH = 6;
  localparam int DEF_DATA_WIDTH = 16;

  // Sequencer states: INIT runs the zeroing sweep, RUN serves the CPU
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage : memory_responder_pkg

// File: rtl/memory_responder_if.sv
// CPU memory bus plus the secondary loader write port, bundled so the CPU /
// loader side (master) and the responder (slave) share one definition.
interface memory_responder_if
  import memory_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

  // CPU side
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [DATA_WIDTH-1:0] mem_in;

  // Loader side
  logic                  ld_valid;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  ld_ready;

  // Status
  logic                  busy;

  modport master (
    output mem_we, mem_addr, mem_data, ld_valid, ld_addr, ld_data,
    input  mem_in, ld_ready, busy
  );

  modport slave (
    input  mem_we, mem_addr, mem_data, ld_valid, ld_addr, ld_data,
    output mem_in, ld_ready, busy
  );

endinterface : memory_responder_if

// File: rtl/memory_responder_ram_array.sv
// Single-write-port memory array with a registered, read-first read port.
// When the read enable is low the read register loads zero, so nothing in
// the array can reach the output while reads are disabled.
module memory_responder_ram_array #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  // Storage write port; contents are not reset (cleared by the sweep instead)
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read register: samples the pre-write value of the addressed word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem_r[raddr];
    end else begin
      rdata <= '0;
    end
  end

endmodule : memory_responder_ram_array

// File: rtl/memory_responder.sv
// Responder for the CPU memory interface. After reset it zeroes every word
// (busy high), then serves CPU reads/writes with one-cycle read latency and
// accepts loader writes whenever the CPU is not writing.
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input logic                clk,
  input logic                rst_n,
  memory_responder_if.slave  bus
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ONE_ADDR  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_e                state_r;
  logic [ADDR_WIDTH-1:0] cnt_r;
  logic                  busy_r;

  logic                  ram_we_s;
  logic [ADDR_WIDTH-1:0] ram_waddr_s;
  logic [DATA_WIDTH-1:0] ram_wdata_s;
  logic                  ram_re_s;
  logic [DATA_WIDTH-1:0] ram_rdata_s;
  logic                  ld_ready_s;

  // Sequencer: zeroing sweep over every address, then RUN until next reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_INIT;
      cnt_r   <= '0;
      busy_r  <= 1'b1;
    end else begin
      case (state_r)
        ST_INIT: begin
          if (cnt_r == LAST_ADDR) begin
            state_r <= ST_RUN;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
          end else begin
            state_r <= ST_INIT;
            cnt_r   <= cnt_r + ONE_ADDR;
            busy_r  <= 1'b1;
          end
        end
        ST_RUN: begin
          state_r <= ST_RUN;
          cnt_r   <= cnt_r;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_INIT;
          cnt_r   <= '0;
          busy_r  <= 1'b1;
        end
      endcase
    end
  end

  // Loader may write only in RUN and only when the CPU is not writing
  always_comb begin
    ld_ready_s = 1'b0;
    if ((state_r == ST_RUN) && !bus.mem_we) begin
      ld_ready_s = 1'b1;
    end else begin
      ld_ready_s = 1'b0;
    end
  end

  // Write-port arbitration: sweep in INIT, otherwise CPU over loader
  always_comb begin
    ram_we_s    = 1'b0;
    ram_waddr_s = '0;
    ram_wdata_s = '0;
    if (state_r == ST_INIT) begin
      ram_we_s    = 1'b1;
      ram_waddr_s = cnt_r;
      ram_wdata_s = '0;
    end else if (bus.mem_we) begin
      ram_we_s    = 1'b1;
      ram_waddr_s = bus.mem_addr;
      ram_wdata_s = bus.mem_data;
    end else if (bus.ld_valid && ld_ready_s) begin
      ram_we_s    = 1'b1;
      ram_waddr_s = bus.ld_addr;
      ram_wdata_s = bus.ld_data;
    end else begin
      ram_we_s    = 1'b0;
      ram_waddr_s = '0;
      ram_wdata_s = '0;
    end
  end

  // Reads are enabled only in RUN, so mem_in stays zero through the sweep
  // and in the first RUN cycle (whose read was sampled during INIT)
  always_comb begin
    ram_re_s = 1'b0;
    if (state_r == ST_RUN) begin
      ram_re_s = 1'b1;
    end else begin
      ram_re_s = 1'b0;
    end
  end

  memory_responder_ram_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we_s),
    .waddr (ram_waddr_s),
    .wdata (ram_wdata_s),
    .re    (ram_re_s),
    .raddr (bus.mem_addr),
    .rdata (ram_rdata_s)
  );

  assign bus.mem_in   = ram_rdata_s;
  assign bus.ld_ready = ld_ready_s;
  assign bus.busy     = busy_r;

endmodule : memory_responder

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: sweep timing, INIT write blocking,
// a table of RUN-mode vectors, and a mid-run reset sequence.
module tb_memory_responder;

  logic clk;
  logic rst_n;

  memory_responder_if bus ();

  memory_responder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [5:0]  addr;
    logic [15:0] data;
    logic        ld_valid;
    logic [5:0]  ld_addr;
    logic [15:0] ld_data;
    logic        exp_ready;
    logic [15:0] exp_mem;
  } vec_t;

  vec_t vq[$];
  int   total;
  int   passed;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.mem_we   = 1'b0;
    bus.mem_addr = 6'd0;
    bus.mem_data = 16'h0000;
    bus.ld_valid = 1'b0;
    bus.ld_addr  = 6'd0;
    bus.ld_data  = 16'h0000;
  endtask

  task automatic add(input logic we, input logic [5:0] addr, input logic [15:0] data,
                     input logic ldv, input logic [5:0] lda, input logic [15:0] ldd,
                     input logic er, input logic [15:0] em);
    vec_t v;
    v.we = we; v.addr = addr; v.data = data;
    v.ld_valid = ldv; v.ld_addr = lda; v.ld_data = ldd;
    v.exp_ready = er; v.exp_mem = em;
    vq.push_back(v);
  endtask

  // Wait for the sweep, optionally hammering a CPU write (addr 5, 0xBEEF) and a
  // loader write (addr 6, 0x1111) during the first cycles; both must be dropped.
  task automatic sweep(input string tag, input bit poke);
    int n;
    int rdy_hi;
    int mem_nz;
    n = 0; rdy_hi = 0; mem_nz = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      if (bus.ld_ready !== 1'b0) rdy_hi++;
      if (bus.mem_in !== 16'h0000) mem_nz++;
      if (poke && n < 10) begin
        bus.mem_we = 1'b1; bus.mem_addr = 6'd5; bus.mem_data = 16'hBEEF;
        bus.ld_valid = 1'b1; bus.ld_addr = 6'd6; bus.ld_data = 16'h1111;
      end else begin
        idle();
      end
      tick();
      n++;
    end
    check({tag, "_busy_cycles"}, 16'(n), 16'd64);
    check({tag, "_ld_ready_hi_in_init"}, 16'(rdy_hi), 16'd0);
    check({tag, "_mem_in_nonzero_in_init"}, 16'(mem_nz), 16'd0);
    check({tag, "_first_run_mem_in"}, bus.mem_in, 16'h0000);
  endtask

  initial begin
    total = 0;
    passed = 0;
    rst_n = 1'b0;
    idle();

    // Reset state
    #12;
    check("reset_mem_in", bus.mem_in, 16'h0000);
    check("reset_busy", {15'd0, bus.busy}, 16'd1);
    check("reset_ld_ready", {15'd0, bus.ld_ready}, 16'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("init_ld_ready_after_release", {15'd0, bus.ld_ready}, 16'd0);

    sweep("sweep1", 1'b1);

    // RUN vectors: exp_mem is mem_in in the cycle after the vector is applied
    add(1'b0, 6'd0,  16'h0000, 1'b0, 6'd0,  16'h0000, 1'b1, 16'h0000);
    add(1'b0, 6'd8,  16'h0000, 1'b0, 6'd0,  16'h0000, 1'b1, 16'h0000);
    add(1'b0, 6'd63, 16'h0000, 1'b0, 6'd0,  16'h0000, 1'b1, 16'h0000);
    add(1'b0, 6'd5,  16'h0000, 1'b0, 6'd0,  16'h0000, 1'b1, 16'h0000);
    add(1'b0, 6'd6,  16'h0000, 1'b0, 6'd0,  16'h0000, 1'b1, 16'h0000);
    add(1'b1, 6'd8,  16'h1234, 1'b0, 6'd0,  16'h0000, 1'b0, 16'h0000);
    add(1'b0, 6'd8,  16'h0000, 1'b0, 6'd0,  16'h0000, 1'b1, 16'h1234);
    add(1'b1, 6'd8,  16'h5678, 1'b0, 6'd0,  16'h0000, 1'b0, 16'h1234);
    add(1'b0, 6'd8,  16'h0000, 1'b0, 6'd0,  16'h0000, 1'b1, 16'h5678);
    add(1'b1, 6'd10, 16'h0A01, 1'b1, 6'd9,  16'h7F01, 1'b0, 16'h0000);
    add(1'b1, 6'd10, 16'h0A02, 1'b1, 6'd9,  16'h7F01, 1'b0, 16'h0A01);
    add(1'b1, 6'd10, 16'h0A03, 1'b1, 6'd9,  16'h7F01, 1'b0, 16'h0A02);
    add(1'b0, 6'd9,  16'h0000, 1'b1, 6'd9,  16'h7F01, 1'b1, 16'h0000);
    add(1'b0, 6'd9,  16'h0000, 1'b0, 6'd0,  16'h0000, 1'b1, 16'h7F01);
    add(1'b0, 6'd10, 16'h0000, 1'b0, 6'd0,  16'h0000, 1'b1, 16'h0A03);
    add(1'b0, 6'd0,  16'h0000, 1'b1, 6'd8,  16'h1000, 1'b1, 16'h0000);
    add(1'b0, 6'd0,  16'h0000, 1'b1, 6'd9,  16'h2001, 1'b1, 16'h0000);
    add(1'b0, 6'd0,  16'h0000, 1'b1, 6'd10, 16'h3002, 1'b1, 16'h0000);
    add(1'b0, 6'd0,  16'h0000, 1'b1, 6'd11, 16'h4003, 1'b1, 16'h0000);
    add(1'b0, 6'd8,  16'h0000, 1'b0, 6'd0,  16'h0000, 1'b1, 16'h1000);
    add(1'b0, 6'd9,  16'h0000, 1'b0, 6'd0,  16'h0000, 1'b1, 16'h2001);
    add(1'b0, 6'd10, 16'h0000, 1'b0, 6'd0,  16'h0000, 1'b1, 16'h3002);
    add(1'b0, 6'd11, 16'h0000, 1'b0, 6'd0,  16'h0000, 1'b1, 16'h4003);
    add(1'b1, 6'd63, 16'hFFFF, 1'b0, 6'd0,  16'h0000, 1'b0, 16'h0000);
    add(1'b0, 6'd63, 16'h0000, 1'b0, 6'd0,  16'h0000, 1'b1, 16'hFFFF);
    add(1'b1, 6'd0,  16'h8001, 1'b0, 6'd0,  16'h0000, 1'b0, 16'h0000);
    add(1'b0, 6'd0,  16'h0000, 1'b0, 6'd0,  16'h0000, 1'b1, 16'h8001);

    for (int i = 0; i < vq.size(); i++) begin
      bus.mem_we   = vq[i].we;
      bus.mem_addr = vq[i].addr;
      bus.mem_data = vq[i].data;
      bus.ld_valid = vq[i].ld_valid;
      bus.ld_addr  = vq[i].ld_addr;
      bus.ld_data  = vq[i].ld_data;
      #1;
      check($sformatf("vec%0d_ld_ready", i), {15'd0, bus.ld_ready}, {15'd0, vq[i].exp_ready});
      tick();
      check($sformatf("vec%0d_mem_in", i), bus.mem_in, vq[i].exp_mem);
      check($sformatf("vec%0d_busy", i), {15'd0, bus.busy}, 16'd0);
    end
    idle();

    // Mid-run reset: addr 20 holds 0xAAAA, then reset must clear outputs at once
    bus.mem_we = 1'b1; bus.mem_addr = 6'd20; bus.mem_data = 16'hAAAA;
    tick();
    bus.mem_we = 1'b0; bus.mem_addr = 6'd20;
    tick();
    tick();
    check("pre_reset_addr20", bus.mem_in, 16'hAAAA);
    rst_n = 1'b0;
    #1;
    check("midrun_reset_busy", {15'd0, bus.busy}, 16'd1);
    check("midrun_reset_mem_in", bus.mem_in, 16'h0000);
    check("midrun_reset_ld_ready", {15'd0, bus.ld_ready}, 16'd0);
    tick();
    tick();
    rst_n = 1'b1;
    sweep("sweep2", 1'b0);
    bus.mem_addr = 6'd20;
    tick();
    check("post_reset_addr20", bus.mem_in, 16'h0000);
    bus.mem_addr = 6'd63;
    tick();
    check("post_reset_addr63", bus.mem_in, 16'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_memory_responder
